// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes (also used by the
// E-stage decoder), FSM state encoding and default latencies.
package mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8,
    MD_MSUB  = 4'd9,
    MD_MSUBU = 4'd10
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
  localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_if.sv
// Issue/result bundle between the E stage and the multiply/divide unit.
interface mdu_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output start, op, A, B, input  busy, HI, LO);
  modport slave  (input  start, op, A, B, output busy, HI, LO);
endinterface

// File: rtl/mdu_alu.sv
// Combinational 64-bit {HI,LO} result generator for the latched md operation.
// MDU_MADD_EN adds madd/maddu/msub/msubu accumulate forms.
module mdu_alu
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [63:0] hilo,
  output logic [63:0] res,
  output logic        we
);

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] sa;
  logic signed [31:0] sb;
  logic signed [31:0] sq;
  logic signed [31:0] sr;

  always_comb begin
    // Low 64 bits of the sign-extended product equal the signed product.
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'd0, a} * {32'd0, b};
    sa     = a;
    sb     = b;
    sq     = sa / sb;
    sr     = sa % sb;
    res    = hilo;
    we     = 1'b0;
    case (op)
      MD_MULT:  begin res = prod_s; we = 1'b1; end
      MD_MULTU: begin res = prod_u; we = 1'b1; end
      MD_DIV: begin
        if (b != '0) begin
          we = 1'b1;
          if (a == 32'h8000_0000 && b == '1) res = {32'd0, 32'h8000_0000};
          else                               res = {sr, sq};
        end
      end
      MD_DIVU: begin
        if (b != '0) begin
          we  = 1'b1;
          res = {a % b, a / b};
        end
      end
`ifdef MDU_MADD_EN
      MD_MADD:  begin res = hilo + prod_s; we = 1'b1; end
      MD_MADDU: begin res = hilo + prod_u; we = 1'b1; end
      MD_MSUB:  begin res = hilo - prod_s; we = 1'b1; end
      MD_MSUBU: begin res = hilo - prod_u; we = 1'b1; end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: fixed-latency sequencing FSM and HI/LO owner.
// MDU_MADD_EN enables the madd/maddu/msub/msubu ops (MULT_CYCLES latency).
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic    clk,
  input  logic    reset,
  mdu_if.slave    bus
);

  localparam int unsigned MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  mdu_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [3:0]  op_q, op_d;
  logic        busy_q, busy_d;
  logic        mult_cls, div_cls;
  logic [63:0] alu_res;
  logic        alu_we;

  mdu_alu u_alu (
    .op   (op_q),
    .a    (a_q),
    .b    (b_q),
    .hilo ({hi_q, lo_q}),
    .res  (alu_res),
    .we   (alu_we)
  );

  always_comb begin
    mult_cls = (bus.op == MD_MULT) || (bus.op == MD_MULTU);
`ifdef MDU_MADD_EN
    mult_cls = mult_cls || (bus.op == MD_MADD) || (bus.op == MD_MADDU) ||
               (bus.op == MD_MSUB) || (bus.op == MD_MSUBU);
`endif
    div_cls  = (bus.op == MD_DIV) || (bus.op == MD_DIVU);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (mult_cls || div_cls) begin
            a_d     = bus.A;
            b_d     = bus.B;
            op_d    = bus.op;
            cnt_d   = mult_cls ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
            state_d = ST_RUN;
            busy_d  = 1'b1;
          end else if (bus.op == MD_MTHI) begin
            hi_d = bus.A;
          end else if (bus.op == MD_MTLO) begin
            lo_d = bus.A;
          end
        end
      end
      ST_RUN: begin
        // start is deliberately not looked at here, mthi/mtlo included.
        if (cnt_q == '0) begin
          if (alu_we) begin
            hi_d = alu_res[63:32];
            lo_d = alu_res[31:0];
          end
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule
